// File: rtl/i2s_spdif_feeder.sv
// i2s_spdif_feeder: I2S (24-bit, oversampled) to stereo-pair FIFO feeding the
// S/PDIF transmitter. Each i_dreq returns one pair with a one-cycle o_drdy.
// Optional feature macro: SPDIF_FEED_HOLD_LAST_EN (hold last pair on underrun;
// default build mutes to zero).
module i2s_spdif_feeder #(
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_bclk,
  input  logic               i_lrclk,
  input  logic               i_sdata,
  input  logic               i_dreq,
  input  logic               i_clr_flags,
  output logic [23:0]        o_ldata,
  output logic [23:0]        o_rdata,
  output logic               o_drdy,
  output logic [FIFO_AW:0]   o_level,
  output logic               o_underrun,
  output logic               o_overflow
);

  localparam int unsigned DW    = 24;
  localparam int unsigned CW    = 5;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;

`ifdef SPDIF_FEED_HOLD_LAST_EN
  localparam bit HoldLast = 1'b1;
`else
  localparam bit HoldLast = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, ws_sync_q, sd_sync_q;
  logic                   bclk_s, ws_s, sd_s;

  logic                   bclk_prev_q, ws_prev_q, armed_q, lvalid_q;
  logic                   ws_prev_d, armed_d, lvalid_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          word_q, word_d, lhold_q, lhold_d, word_fill_c;
  logic                   bclk_rise_c, push_c;
  pair_t                  push_pair_c;

  pair_t                  mem_q [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q;
  logic                   empty_c, full_c, pop_c, wr_en_c, udr_evt_c, ovf_evt_c;

  logic [DW-1:0]          ldata_q, rdata_q;
  logic                   drdy_q, udr_q, ovf_q;

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign ws_s   = ws_sync_q[SYNC_STAGES-1];
  assign sd_s   = sd_sync_q[SYNC_STAGES-1];

  // Synchronise the asynchronous I2S lines into the i_clk domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync_q <= '0;
      ws_sync_q   <= '0;
      sd_sync_q   <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i_bclk};
      ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], i_lrclk};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], i_sdata};
    end
  end

  // Deserialiser next state: capture on bclk rise, close word on ws change.
  always_comb begin
    bclk_rise_c = bclk_s & ~bclk_prev_q;
    word_fill_c = word_q;
    if (cnt_q < CW'(DW)) word_fill_c[CW'(DW - 1) - cnt_q] = sd_s;
    cnt_d       = cnt_q;
    word_d      = word_q;
    ws_prev_d   = ws_prev_q;
    armed_d     = armed_q;
    lvalid_d    = lvalid_q;
    lhold_d     = lhold_q;
    push_c      = 1'b0;
    push_pair_c = {lhold_q, word_fill_c};
    if (bclk_rise_c) begin
      ws_prev_d = ws_s;
      if (ws_s != ws_prev_q) begin
        // This bit is the LSB slot of the ending word; the first boundary only arms.
        cnt_d   = '0;
        word_d  = '0;
        armed_d = 1'b1;
        if (armed_q) begin
          if (!ws_prev_q) begin
            lhold_d  = word_fill_c;
            lvalid_d = 1'b1;
          end else if (lvalid_q) begin
            push_c   = 1'b1;
            lvalid_d = 1'b0;
          end
        end
      end else begin
        word_d = word_fill_c;
        if (cnt_q < CW'(DW)) cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Deserialiser state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_prev_q <= 1'b0;
      ws_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      lvalid_q    <= 1'b0;
      cnt_q       <= '0;
      word_q      <= '0;
      lhold_q     <= '0;
    end else begin
      bclk_prev_q <= bclk_s;
      ws_prev_q   <= ws_prev_d;
      armed_q     <= armed_d;
      lvalid_q    <= lvalid_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      lhold_q     <= lhold_d;
    end
  end

  // FIFO control: a pop frees a slot for a same-cycle push when full.
  always_comb begin
    empty_c   = (level_q == '0);
    full_c    = (level_q == LW'(DEPTH));
    pop_c     = i_dreq & ~empty_c;
    wr_en_c   = push_c & (~full_c | pop_c);
    ovf_evt_c = push_c & full_c & ~pop_c;
    udr_evt_c = i_dreq & empty_c;
  end

  // Pair storage (no reset needed; validity is tracked by the pointers).
  always_ff @(posedge i_clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= push_pair_c;
  end

  // Pointers, level, output data, strobe and sticky flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ldata_q  <= '0;
      rdata_q  <= '0;
      drdy_q   <= 1'b0;
      udr_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      drdy_q <= i_dreq;
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_c)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (wr_en_c && !pop_c)      level_q <= level_q + LW'(1);
      else if (pop_c && !wr_en_c) level_q <= level_q - LW'(1);
      if (pop_c) begin
        ldata_q <= mem_q[rd_ptr_q].l;
        rdata_q <= mem_q[rd_ptr_q].r;
      end else if (udr_evt_c && !HoldLast) begin
        ldata_q <= '0;
        rdata_q <= '0;
      end
      if (udr_evt_c)        udr_q <= 1'b1;
      else if (i_clr_flags) udr_q <= 1'b0;
      if (ovf_evt_c)        ovf_q <= 1'b1;
      else if (i_clr_flags) ovf_q <= 1'b0;
    end
  end

  assign o_ldata    = ldata_q;
  assign o_rdata    = rdata_q;
  assign o_drdy     = drdy_q;
  assign o_level    = level_q;
  assign o_underrun = udr_q;
  assign o_overflow = ovf_q;

endmodule
